// File: rtl/magic_read_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the blackbox data port.
// No logic; the slave modport is the arbiter's view, the master modport the environment's.
// Widths follow the arbiter parameters and must be instantiated with matching values.
interface magic_read_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int SEL_W  = 12,
   parameter int DATA_W = 64
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*SEL_W-1:0] req_select;
   logic [NREQ-1:0]       resp_valid;
   logic [NREQ-1:0]       resp_ready;
   logic [DATA_W-1:0]     resp_data;
   logic [SEL_W-1:0]      mb_read_select;
   logic                  mb_read_ready;
   logic                  mb_read_valid;
   logic [DATA_W-1:0]     mb_read_data;

   modport slave (
      input  req_valid, req_select, resp_ready, mb_read_valid, mb_read_data,
      output req_ready, resp_valid, resp_data, mb_read_select, mb_read_ready
   );

   modport master (
      output req_valid, req_select, resp_ready, mb_read_valid, mb_read_data,
      input  req_ready, resp_valid, resp_data, mb_read_select, mb_read_ready
   );
endinterface

// File: rtl/magic_read_arbiter.sv
// Round-robin sharing of the single blackbox read port among NREQ requesters.
// Latency: accept at T, blackbox query in T+1, response valid from T+2 (3 cycles minimum).
// Backpressure: one transaction in flight; response held until the granted requester accepts.
module magic_read_arbiter #(
   parameter int NREQ   = 4,
   parameter int SEL_W  = 12,
   parameter int DATA_W = 64
) (
   input  logic                clock,
   input  logic                reset,
   magic_read_arbiter_if.slave bus,
   output logic                busy,
   output logic [31:0]         xact_count
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    gnt_q;
   logic [SEL_W-1:0]    sel_q;
   logic [DATA_W-1:0]   data_q;

   logic [PTR_W-1:0]    pick;
   logic                pick_vld;
   int                  scan_idx;

   logic                accept;
   logic                capture;
   logic                complete;
   logic [NREQ-1:0]     req_ready_c;
   logic [NREQ-1:0]     resp_valid_c;
   logic [DATA_W-1:0]   resp_data_c;
   logic [SEL_W-1:0]    mb_select_c;
   logic                mb_ready_c;

   // Round-robin scan: first requester at or after rr_ptr, wrapping around.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      scan_idx = 0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = (int'(rr_ptr) + k) % NREQ;
         if (!pick_vld && bus.req_valid[scan_idx]) begin
            pick_vld = 1'b1;
            pick     = PTR_W'(scan_idx);
         end
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; every output defaults low so only the
   // current phase's signals are ever asserted.
   always_comb begin
      state_d      = state_q;
      req_ready_c  = '0;
      resp_valid_c = '0;
      resp_data_c  = '0;
      mb_select_c  = '0;
      mb_ready_c   = 1'b0;
      accept       = 1'b0;
      capture      = 1'b0;
      complete     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               req_ready_c[pick] = 1'b1;
               accept            = 1'b1;
               state_d           = ISSUE;
            end
         end
         ISSUE: begin
            mb_ready_c  = 1'b1;
            mb_select_c = sel_q;
            if (bus.mb_read_valid) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid_c[gnt_q] = 1'b1;
            resp_data_c         = data_q;
            // Only the granted requester's accept counts.
            if (bus.resp_ready[gnt_q]) begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Transaction datapath: latch the grant, capture the returned word, count completions.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr     <= '0;
         gnt_q      <= '0;
         sel_q      <= '0;
         data_q     <= '0;
         xact_count <= '0;
      end else begin
         if (accept) begin
            sel_q  <= bus.req_select[int'(pick)*SEL_W +: SEL_W];
            gnt_q  <= pick;
            rr_ptr <= (pick == PTR_W'(NREQ-1)) ? '0 : pick + PTR_W'(1);
         end
         if (capture) begin
            data_q <= bus.mb_read_data;
         end
         if (complete) begin
            xact_count <= xact_count + 32'd1;
         end
      end
   end

   assign bus.req_ready      = req_ready_c;
   assign bus.resp_valid     = resp_valid_c;
   assign bus.resp_data      = resp_data_c;
   assign bus.mb_read_select = mb_select_c;
   assign bus.mb_read_ready  = mb_ready_c;
   assign busy               = (state_q != IDLE);
endmodule
